// File: rtl/apb_bcd_convertor.sv
// APB-programmable binary<->BCD converter (double dabble / reverse double dabble).
// Latency: APB one wait state; conversion DATA_WIDTH cycles after START, invalid BCD flagged in 1.
// Backpressure: pready held 0 for one access cycle; START while busy is dropped and flags OVR.
module apb_bcd_convertor #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  mod_ready
);

    localparam int BCD_W  = 4 * BCD_DIGITS;
    localparam int WORK_W = BCD_W + DATA_WIDTH;
    localparam int RES_W  = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int OP_NIB = DATA_WIDTH / 4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OPERAND = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RES_LO  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RES_HI  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(4);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  mode_q;
    logic                  conv_mode_q;
    logic [WORK_W-1:0]     work_q;
    logic [WORK_W-1:0]     work_step;
    logic [CNT_W-1:0]      cnt_q;
    logic [RES_W-1:0]      result_q;
    logic [RES_W-1:0]      result_next;
    logic                  done_q;
    logic                  err_q;
    logic                  ovr_q;
    logic [DATA_WIDTH-1:0] rd_dat;

    logic wr_en;
    logic rd_phase;
    logic wr_ctrl;
    logic wr_operand;
    logic wr_status;
    logic busy;
    logic start_req;
    logic start_ok;
    logic start_ovr;
    logic bcd_bad;
    logic invalid;
    logic last_step;

    // A write lands on the edge closing the pready=1 cycle; read data is captured one edge earlier.
    assign wr_en      = psel & penable & pready & pwrite;
    assign rd_phase   = psel & penable & ~pready;
    assign wr_ctrl    = wr_en && (paddr == ADDR_CTRL);
    assign wr_operand = wr_en && (paddr == ADDR_OPERAND);
    assign wr_status  = wr_en && (paddr == ADDR_STATUS);

    assign busy      = (state_q == ST_SHIFT);
    assign start_req = wr_ctrl & pwdata[0];
    assign start_ok  = start_req & ~busy;
    assign start_ovr = start_req & busy;
    assign invalid   = start_ok & pwdata[1] & bcd_bad;
    assign last_step = busy && (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // Flag any operand nibble that is not a decimal digit.
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < OP_NIB; i++) begin
            if (operand_q[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // One conversion step: BCD field sits above the binary field in the working register.
    always_comb begin
        work_step = work_q;
        if (!conv_mode_q) begin
            for (int i = 0; i < BCD_DIGITS; i++) begin
                if (work_step[DATA_WIDTH + 4*i +: 4] >= 4'd5) begin
                    work_step[DATA_WIDTH + 4*i +: 4] = work_step[DATA_WIDTH + 4*i +: 4] + 4'd3;
                end
            end
            work_step = {work_step[WORK_W-2:0], 1'b0};
        end else begin
            work_step = {1'b0, work_step[WORK_W-1:1]};
            for (int i = 0; i < BCD_DIGITS; i++) begin
                if (work_step[DATA_WIDTH + 4*i +: 4] >= 4'd8) begin
                    work_step[DATA_WIDTH + 4*i +: 4] = work_step[DATA_WIDTH + 4*i +: 4] - 4'd3;
                end
            end
        end
    end

    // Result seen at the end of the final step, zero-extended to the two-word result.
    always_comb begin
        result_next = '0;
        if (!conv_mode_q) begin
            result_next = RES_W'(work_step[WORK_W-1:DATA_WIDTH]);
        end else begin
            result_next = RES_W'(work_step[DATA_WIDTH-1:0]);
        end
    end

    // Next-state logic: leave IDLE only for a valid START, return after the last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok && !invalid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_step) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mod_ready tracks the upcoming state so it drops on the START edge itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mod_ready <= 1'b1;
        end else begin
            mod_ready <= (state_d != ST_SHIFT);
        end
    end

    // Register read mux; unmapped addresses read zero.
    always_comb begin
        rd_dat = '0;
        case (paddr)
            ADDR_CTRL:    rd_dat = DATA_WIDTH'({mode_q, 1'b0});
            ADDR_OPERAND: rd_dat = operand_q;
            ADDR_RES_LO:  rd_dat = result_q[DATA_WIDTH-1:0];
            ADDR_RES_HI:  rd_dat = result_q[RES_W-1:DATA_WIDTH];
            ADDR_STATUS:  rd_dat = DATA_WIDTH'({ovr_q, err_q, done_q, busy});
            default:      rd_dat = '0;
        endcase
    end

    // APB handshake: one wait state, read data registered on the edge raising pready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pready <= 1'b0;
            prdata <= '0;
        end else begin
            pready <= psel & penable & ~pready;
            if (rd_phase && !pwrite) begin
                prdata <= rd_dat;
            end
        end
    end

    // Programmable registers; a START refused for overrun leaves MODE alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operand_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            if (wr_operand) begin
                operand_q <= pwdata;
            end
            if (wr_ctrl && !start_ovr) begin
                mode_q <= pwdata[1];
            end
        end
    end

    // Conversion datapath: load on START, step while shifting, capture result on the last step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_q      <= '0;
            cnt_q       <= '0;
            conv_mode_q <= 1'b0;
            result_q    <= '0;
        end else if (start_ok) begin
            conv_mode_q <= pwdata[1];
            cnt_q       <= '0;
            if (pwdata[1]) begin
                work_q <= WORK_W'({operand_q, {DATA_WIDTH{1'b0}}});
            end else begin
                work_q <= WORK_W'(operand_q);
            end
            if (invalid) begin
                result_q <= '0;
            end
        end else if (busy) begin
            work_q <= work_step;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_step) begin
                result_q <= result_next;
            end
        end
    end

    // Sticky status flags: write-1-to-clear, hardware set takes priority over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (last_step || invalid) begin
                done_q <= 1'b1;
            end else if (start_ok || (wr_status && pwdata[1])) begin
                done_q <= 1'b0;
            end
            if (invalid) begin
                err_q <= 1'b1;
            end else if (start_ok || (wr_status && pwdata[2])) begin
                err_q <= 1'b0;
            end
            if (start_ovr) begin
                ovr_q <= 1'b1;
            end else if (wr_status && pwdata[3]) begin
                ovr_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/apb_bcd_convertor.md
# apb_bcd_convertor

APB-programmable, parametrised binary/BCD converter; the successor to the fixed 8-bit converter. It sits on the peripheral APB bus and converts one operand per start command. Two modes are provided: binary→BCD (double dabble) and BCD→binary (reverse double dabble), each taking DATA_WIDTH cycles. It adds invalid-digit detection, start-overrun flagging and a split result for BCD outputs wider than the bus.

## Interface
- ADDR_WIDTH, 3: APB word-address width; registers at 0..4.
- DATA_WIDTH, 8: bus, operand and binary width. Must be a multiple of 4 and ≥8.
- BCD_DIGITS, 3: output digits in bin→BCD mode. Requires 10^BCD_DIGITS > 2^DATA_WIDTH and 4·BCD_DIGITS ≤ 2·DATA_WIDTH.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- paddr  in  ADDR_WIDTH  register word address.
- pwrite  in  1  1 = write, 0 = read.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data; valid while pready=1; reset 0.
- pready  out  1  transfer complete; reset 0.
- mod_ready  out  1  converter idle, accepts start; reset 1.

## Operation
- Register map:
  - 0 CTRL (RW): bit0 START (write-1 pulse, reads 0); bit1 MODE (0 = bin→BCD, 1 = BCD→bin).
  - 1 OPERAND (RW).
  - 2 RESULT_LO (RO): result[DATA_WIDTH-1:0].
  - 3 RESULT_HI (RO): result bits above DATA_WIDTH, zero-extended.
  - 4 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); bit3 OVR (W1C).
- Unmapped addresses read 0. Writes to unmapped or read-only addresses are ignored.
- FSM states: IDLE and SHIFT.
- IDLE → SHIFT on an accepted CTRL write with START=1. On that transition:
  - OPERAND is copied into the working shift register.
  - The step counter is cleared.
  - MODE is latched.
  - DONE and ERR are cleared.
- BCD→bin only: if any OPERAND nibble >9, the block skips SHIFT entirely on that same edge: ERR=1, DONE=1, result=0, state stays IDLE.
- SHIFT performs one step per cycle for DATA_WIDTH cycles:
  - bin→BCD: add 3 to every BCD nibble ≥5, then shift left 1.
  - BCD→bin: shift right 1, then subtract 3 from every nibble ≥8.
- On the DATA_WIDTH-th step edge: the result register is loaded (BCD width 4·BCD_DIGITS, or binary width DATA_WIDTH), DONE=1, state → IDLE.
- BUSY = (state==SHIFT). mod_ready = ~BUSY, registered.
- START accepted while BUSY, including on the final step cycle: ignored, OVR=1, in-flight conversion unaffected.
- An OPERAND write while BUSY updates the register but not the in-flight conversion.
- A CTRL write with START=0 updates MODE only.
- A STATUS write of 1 clears the corresponding bit. If the clear coincides with a hardware set on the same edge, the set wins.
- reset low (asynchronous, any time, including mid-conversion):
  - state=IDLE; counters, OPERAND, MODE, result and STATUS bits = 0.
  - pready=0, prdata=0, mod_ready=1.
  - The aborted conversion produces no DONE.

## Timing
- APB uses one wait state.
- Setup cycle: psel=1, penable=0.
- First access cycle: pready=0.
- Second access cycle: pready=1. prdata is registered on the same edge that raises pready. The write takes effect on the edge ending the pready=1 cycle.
- pready returns to 0 the cycle after. Back-to-back transfers are supported (a new setup phase directly follows).
- psel deasserted mid-access: pready stays 0 and no register changes.
- Conversion latency, counted from the START write edge E0:
  - mod_ready=0 and BUSY=1 for cycles E0+1 .. E0+DATA_WIDTH.
  - Result and DONE are visible from E0+DATA_WIDTH.
  - mod_ready=1 again at the same edge.
- BCD→bin with an invalid digit: DONE=1 and ERR=1 at E0+1; mod_ready never drops.
- A STATUS read during the completion edge returns the pre-edge value.

## Test plan
- Reset: assert reset low mid-access → pready=0, prdata=0, mod_ready=1, all registers read 0 after release.
- bin→BCD (default parameters): OPERAND=0xFF, CTRL=0x01 → mod_ready low 8 cycles, then RESULT_LO=0x55, RESULT_HI=0x02, STATUS=0x02. Repeat with 0x00 → 0x00/0x00 and 0x0A → 0x10/0x00.
- BCD→bin: OPERAND=0x99, CTRL=0x03 → after 8 cycles RESULT_LO=0x63, RESULT_HI=0x00, DONE=1, ERR=0.
- Invalid BCD: OPERAND=0x3A, CTRL=0x03 → next cycle STATUS=0x06, RESULT_LO=0, mod_ready stays 1. Write STATUS=0x06 → reads 0x00.
- Overrun: START at E0, second START at E0+4 and another at E0+8 → OVR=1, result from the first operand unchanged, exactly one DONE.
- Parameter sweep: DATA_WIDTH=16, BCD_DIGITS=5, OPERAND=0xFFFF, bin→BCD → 16-cycle busy, RESULT_LO=0x5535, RESULT_HI=0x0006. Then reset low at cycle 7 of a conversion → DONE=0, mod_ready=1.
